// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port, shared memory command
// port and the status outputs. The arbiter connects through the slave
// modport; the environment (CPU side plus memory model) uses master.
interface mem_arbiter_if;
    // Instruction-fetch port
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;

    // Data-memory port
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_sel;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;

    // Shared single-port memory
    logic        mem_ce;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    // Status
    logic        stall_req;
    logic        bus_err;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_sel, dm_addr, dm_wdata,
        input  mem_rdata, mem_ack,
        output if_rdata, if_ready,
        output dm_rdata, dm_ready,
        output mem_ce, mem_we, mem_sel, mem_addr, mem_wdata,
        output stall_req, bus_err
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_sel, dm_addr, dm_wdata,
        output mem_rdata, mem_ack,
        input  if_rdata, if_ready,
        input  dm_rdata, dm_ready,
        input  mem_ce, mem_we, mem_sel, mem_addr, mem_wdata,
        input  stall_req, bus_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter (instruction fetch and data memory) in front of one
// single-port memory. One access is in flight at a time. Data accesses have
// priority, but a waiting fetch is forced through after STARVE_MAX
// consecutive data grants. Accesses that see no mem_ack within TIMEOUT
// cycles are aborted with a bus_err pulse.
//
// Completion timing: the ack edge returns the FSM to IDLE and arms a
// "done" flag; the ready pulse follows one cycle later. No new grant is made
// while a done flag or a ready pulse is active, so a completion handshake
// always finishes before the next access starts.
module mem_arbiter #(
    parameter int unsigned TIMEOUT    = 15,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE_IF = 2'd1,
        SERVE_DM = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [7:0] STARVE_C  = 8'(STARVE_MAX);

    state_t      state_q,    state_d;
    logic [7:0]  starve_q,   starve_d;
    logic [7:0]  wait_q,     wait_d;
    logic [31:0] addr_q,     addr_d;
    logic [31:0] wdata_q,    wdata_d;
    logic [3:0]  sel_q,      sel_d;
    logic        we_q,       we_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        if_done_q,  if_done_d;
    logic        dm_done_q,  dm_done_d;
    logic        err_done_q, err_done_d;
    logic        if_ready_q, if_ready_d;
    logic        dm_ready_q, dm_ready_d;
    logic        bus_err_q,  bus_err_d;

    logic        grant_ok;
    logic        if_wins;

    // A grant is only allowed once every pending completion has been signalled.
    assign grant_ok = ~(if_done_q | dm_done_q | if_ready_q | dm_ready_q);
    // Fetch wins when data is idle or when data has starved it long enough.
    assign if_wins  = bus.if_req & (~bus.dm_req | (starve_q == STARVE_C));

    // State and datapath registers, cleared asynchronously by rst low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            starve_q   <= 8'd0;
            wait_q     <= 8'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            sel_q      <= 4'd0;
            we_q       <= 1'b0;
            if_rdata_q <= 32'd0;
            dm_rdata_q <= 32'd0;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
            err_done_q <= 1'b0;
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            wait_q     <= wait_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_done_q  <= if_done_d;
            dm_done_q  <= dm_done_d;
            err_done_q <= err_done_d;
            if_ready_q <= if_ready_d;
            dm_ready_q <= dm_ready_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // Next-state logic: grant, wait/timeout tracking and completion capture.
    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        wait_d     = wait_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        sel_d      = sel_q;
        we_d       = we_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_done_d  = 1'b0;
        dm_done_d  = 1'b0;
        err_done_d = 1'b0;
        // Ready and error pulses are the done flags delayed by one cycle.
        if_ready_d = if_done_q;
        dm_ready_d = dm_done_q;
        bus_err_d  = err_done_q;

        case (state_q)
            IDLE: begin
                // mem_ack is deliberately ignored here.
                if (grant_ok) begin
                    if (if_wins) begin
                        state_d  = SERVE_IF;
                        addr_d   = bus.if_addr;
                        wait_d   = 8'd0;
                        starve_d = 8'd0;
                    end else if (bus.dm_req) begin
                        state_d = SERVE_DM;
                        addr_d  = bus.dm_addr;
                        wdata_d = bus.dm_wdata;
                        sel_d   = bus.dm_sel;
                        we_d    = bus.dm_we;
                        wait_d  = 8'd0;
                        if (bus.if_req && (starve_q != STARVE_C)) begin
                            starve_d = starve_q + 8'd1;
                        end
                    end
                end
            end

            SERVE_IF: begin
                // Ack takes precedence over a timeout reached in the same cycle.
                if (bus.mem_ack) begin
                    if_rdata_d = bus.mem_rdata;
                    if_done_d  = 1'b1;
                    state_d    = IDLE;
                end else if ((wait_q + 8'd1) == TIMEOUT_C) begin
                    if_rdata_d = 32'd0;
                    if_done_d  = 1'b1;
                    err_done_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            SERVE_DM: begin
                // Writes never touch dm_rdata, whether they complete or abort.
                if (bus.mem_ack) begin
                    if (!we_q) begin
                        dm_rdata_d = bus.mem_rdata;
                    end
                    dm_done_d = 1'b1;
                    state_d   = IDLE;
                end else if ((wait_q + 8'd1) == TIMEOUT_C) begin
                    if (!we_q) begin
                        dm_rdata_d = 32'd0;
                    end
                    dm_done_d  = 1'b1;
                    err_done_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory command: strobes decoded from the state, address/data from the
    // latched registers so they hold their last value while idle.
    assign bus.mem_ce    = (state_q != IDLE);
    assign bus.mem_we    = (state_q == SERVE_DM) & we_q;
    assign bus.mem_sel   = (state_q == SERVE_IF) ? 4'hF :
                           (state_q == SERVE_DM) ? sel_q : 4'h0;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dm_ready  = dm_ready_q;
    assign bus.bus_err   = bus_err_q;

    // Stall while either requester is still waiting for its completion.
    assign bus.stall_req = (bus.if_req & ~if_ready_q) | (bus.dm_req & ~dm_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. A memory responder acks after a
// programmable number of wait cycles; expected completions are queued when a
// request is driven and popped when the matching ready pulse appears.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .TIMEOUT    (15),
        .STARVE_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        dm;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;
    int ack_wait = 0;   // SERVE cycles before ack; negative = never ack
    bit idle_ack = 1'b0;
    int ce_cnt = 0;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h3C01_1234;
        return {a[15:0] ^ 16'hA5A5, a[15:0]};
    endfunction

    function automatic exp_t mk(input logic dm, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.dm = dm;
        e.rdata = rdata;
        e.err = err;
        return e;
    endfunction

    // Memory responder: updates ack/rdata away from the active edge.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (bus.mem_ce === 1'b1) begin
                bus.mem_ack   = (ack_wait >= 0) && (ce_cnt == ack_wait);
                bus.mem_rdata = mem_model(bus.mem_addr);
                ce_cnt++;
            end else begin
                ce_cnt        = 0;
                bus.mem_ack   = idle_ack;
                bus.mem_rdata = 32'hDEAD_BEEF;
            end
        end
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input bit dm, input int budget, output int cycles,
                              output int ce_cycles, output bit ok);
        ok = 1'b0;
        cycles = 0;
        ce_cycles = 0;
        while (!ok && cycles < budget) begin
            tick();
            cycles++;
            if (bus.mem_ce === 1'b1) ce_cycles++;
            if ((dm ? bus.dm_ready : bus.if_ready) === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = 32'd0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_sel = 4'd0;
        bus.dm_addr = 32'd0; bus.dm_wdata = 32'd0;
        repeat (3) tick();
        n_cmp++;
        if (bus.mem_ce !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_sel !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_mem_ctl: ce=%b we=%b sel=%b, required 0 0 0", bus.mem_ce, bus.mem_we, bus.mem_sel);
        end
        n_cmp++;
        if (bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_mem_data: addr=%h wdata=%h, required 0 0", bus.mem_addr, bus.mem_wdata);
        end
        n_cmp++;
        if (bus.if_rdata !== 32'd0 || bus.dm_rdata !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_rdata: if_rdata=%h dm_rdata=%h, required 0 0", bus.if_rdata, bus.dm_rdata);
        end
        n_cmp++;
        if (bus.if_ready !== 1'b0 || bus.dm_ready !== 1'b0 || bus.bus_err !== 1'b0 || bus.stall_req !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_status: if_ready=%b dm_ready=%b bus_err=%b stall=%b, required 0 0 0 0",
                     bus.if_ready, bus.dm_ready, bus.bus_err, bus.stall_req);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        exp_t e;
        int cyc, ce_cyc;
        bit ok;
        ack_wait = 0;
        bus.if_addr = 32'h0000_0010;
        bus.if_req  = 1'b1;
        sb.push_back(mk(1'b0, 32'h3C01_1234, 1'b0));
        tick();
        n_cmp++;
        if (bus.mem_ce !== 1'b1 || bus.mem_addr !== 32'h10 || bus.mem_sel !== 4'hF || bus.mem_we !== 1'b0) begin
            n_bad++;
            $display("FAIL fetch_cmd: ce=%b addr=%h sel=%b we=%b, required 1 00000010 1111 0",
                     bus.mem_ce, bus.mem_addr, bus.mem_sel, bus.mem_we);
        end
        n_cmp++;
        if (bus.stall_req !== 1'b1) begin
            n_bad++;
            $display("FAIL fetch_stall_busy: stall=%b, required 1", bus.stall_req);
        end
        wait_ready(1'b0, 20, cyc, ce_cyc, ok);
        n_cmp++;
        if (!ok || cyc != 2 || ce_cyc != 0) begin
            n_bad++;
            $display("FAIL fetch_latency: ready=%b cycles_after_grant=%0d extra_ce=%0d, required 1 2 0", ok, cyc, ce_cyc);
        end
        e = sb.pop_front();
        $display("txn IF addr=00000010 rdata=%h err=%b", bus.if_rdata, bus.bus_err);
        n_cmp++;
        if (bus.if_rdata !== e.rdata || bus.bus_err !== e.err) begin
            n_bad++;
            $display("FAIL fetch_data: rdata=%h err=%b, required %h %b", bus.if_rdata, bus.bus_err, e.rdata, e.err);
        end
        bus.if_req = 1'b0;
        tick();
        n_cmp++;
        if (bus.stall_req !== 1'b0 || bus.if_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL fetch_after: stall=%b if_ready=%b, required 0 0", bus.stall_req, bus.if_ready);
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        int got, guard, stall_bad;
        ack_wait = 2;
        bus.dm_addr = 32'h0000_0100; bus.dm_we = 1'b0; bus.dm_sel = 4'hF;
        bus.if_addr = 32'h0000_0020;
        bus.dm_req = 1'b1;
        bus.if_req = 1'b1;
        sb.push_back(mk(1'b1, mem_model(32'h100), 1'b0));
        sb.push_back(mk(1'b0, mem_model(32'h20), 1'b0));
        got = 0; guard = 0; stall_bad = 0;
        while (got < 2 && guard < 100) begin
            tick();
            guard++;
            if (bus.if_ready === 1'b1 || bus.dm_ready === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL sim_extra: unexpected ready if=%b dm=%b, required none", bus.if_ready, bus.dm_ready);
                end else begin
                    e = sb.pop_front();
                    $display("txn %s rdata=%h", bus.dm_ready ? "DM" : "IF", bus.dm_ready ? bus.dm_rdata : bus.if_rdata);
                    if (bus.dm_ready !== e.dm || (e.dm ? bus.dm_rdata : bus.if_rdata) !== e.rdata) begin
                        n_bad++;
                        $display("FAIL sim_order: dm_ready=%b rdata=%h, required dm=%b rdata=%h", bus.dm_ready,
                                 bus.dm_ready ? bus.dm_rdata : bus.if_rdata, e.dm, e.rdata);
                    end
                end
                if (bus.if_ready !== 1'b1 && bus.stall_req !== 1'b1) stall_bad++;
                if (bus.if_ready === 1'b1 && bus.stall_req !== 1'b0) stall_bad++;
                got++;
                if (bus.dm_ready === 1'b1) bus.dm_req = 1'b0;
                else bus.if_req = 1'b0;
            end else if (bus.stall_req !== 1'b1) begin
                stall_bad++;
            end
        end
        n_cmp++;
        if (got != 2) begin
            n_bad++;
            $display("FAIL sim_timeout: completions=%0d, required 2", got);
        end
        n_cmp++;
        if (stall_bad != 0) begin
            n_bad++;
            $display("FAIL sim_stall: bad stall cycles=%0d, required 0", stall_bad);
        end
        bus.dm_req = 1'b0; bus.if_req = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_store();
        exp_t e;
        int cyc, ce_cyc;
        bit ok;
        ack_wait = 1;
        bus.dm_addr = 32'h0000_0200; bus.dm_we = 1'b1; bus.dm_sel = 4'b0011;
        bus.dm_wdata = 32'hAABB_CCDD;
        bus.dm_req = 1'b1;
        sb.push_back(mk(1'b1, mem_model(32'h100), 1'b0));
        tick();
        n_cmp++;
        if (bus.mem_ce !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_sel !== 4'b0011 ||
            bus.mem_wdata !== 32'hAABB_CCDD || bus.mem_addr !== 32'h200) begin
            n_bad++;
            $display("FAIL store_cmd: ce=%b we=%b sel=%b wdata=%h addr=%h, required 1 1 0011 aabbccdd 00000200",
                     bus.mem_ce, bus.mem_we, bus.mem_sel, bus.mem_wdata, bus.mem_addr);
        end
        wait_ready(1'b1, 20, cyc, ce_cyc, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL store_ready: dm_ready=%b, required 1", ok);
        end
        e = sb.pop_front();
        $display("txn DM store addr=00000200 dm_rdata=%h", bus.dm_rdata);
        n_cmp++;
        if (bus.dm_rdata !== e.rdata) begin
            n_bad++;
            $display("FAIL store_rdata: dm_rdata=%h, required %h", bus.dm_rdata, e.rdata);
        end
        bus.dm_req = 1'b0; bus.dm_we = 1'b0;
        tick();
        n_cmp++;
        if (bus.mem_ce !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_sel !== 4'd0 ||
            bus.mem_addr !== 32'h200 || bus.mem_wdata !== 32'hAABB_CCDD) begin
            n_bad++;
            $display("FAIL idle_hold: ce=%b we=%b sel=%b addr=%h wdata=%h, required 0 0 0000 00000200 aabbccdd",
                     bus.mem_ce, bus.mem_we, bus.mem_sel, bus.mem_addr, bus.mem_wdata);
        end
    endtask

    task automatic test_starve();
        exp_t e;
        int got, guard;
        bit busy;
        ack_wait = 0;
        bus.dm_addr = 32'h0000_0400; bus.dm_we = 1'b0; bus.dm_sel = 4'hF;
        bus.if_addr = 32'h0000_0300;
        for (int k = 0; k < 10; k++) begin
            if ((k % 5) != 4) sb.push_back(mk(1'b1, mem_model(32'h400), 1'b0));
            else sb.push_back(mk(1'b0, mem_model(32'h300), 1'b0));
        end
        bus.dm_req = 1'b1;
        bus.if_req = 1'b1;
        got = 0; guard = 0;
        while (got < 10 && guard < 300) begin
            tick();
            guard++;
            if (bus.if_ready === 1'b1 || bus.dm_ready === 1'b1) begin
                e = sb.pop_front();
                $display("txn %s #%0d rdata=%h", bus.dm_ready ? "DM" : "IF", got,
                         bus.dm_ready ? bus.dm_rdata : bus.if_rdata);
                n_cmp++;
                if (bus.dm_ready !== e.dm || (e.dm ? bus.dm_rdata : bus.if_rdata) !== e.rdata) begin
                    n_bad++;
                    $display("FAIL starve_order #%0d: dm_ready=%b rdata=%h, required dm=%b rdata=%h", got,
                             bus.dm_ready, bus.dm_ready ? bus.dm_rdata : bus.if_rdata, e.dm, e.rdata);
                end
                got++;
            end
        end
        bus.dm_req = 1'b0;
        bus.if_req = 1'b0;
        n_cmp++;
        if (got != 10) begin
            n_bad++;
            $display("FAIL starve_timeout: completions=%0d, required 10", got);
        end
        busy = 1'b0;
        repeat (4) begin
            tick();
            if (bus.mem_ce === 1'b1 || bus.if_ready === 1'b1 || bus.dm_ready === 1'b1) busy = 1'b1;
        end
        n_cmp++;
        if (busy) begin
            n_bad++;
            $display("FAIL starve_drain: activity after release=%b, required 0", busy);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int cyc, ce_cyc;
        bit ok;
        ack_wait = -1;
        bus.if_addr = 32'h0000_0040;
        bus.if_req = 1'b1;
        sb.push_back(mk(1'b0, 32'd0, 1'b1));
        wait_ready(1'b0, 40, cyc, ce_cyc, ok);
        e = sb.pop_front();
        $display("txn IF addr=00000040 timeout rdata=%h err=%b", bus.if_rdata, bus.bus_err);
        n_cmp++;
        if (!ok || ce_cyc != 15) begin
            n_bad++;
            $display("FAIL timeout_len: ready=%b ce_cycles=%0d, required 1 15", ok, ce_cyc);
        end
        n_cmp++;
        if (bus.bus_err !== e.err || bus.if_rdata !== e.rdata) begin
            n_bad++;
            $display("FAIL timeout_err: bus_err=%b if_rdata=%h, required %b %h", bus.bus_err, bus.if_rdata, e.err, e.rdata);
        end
        bus.if_req = 1'b0;
        tick();
        n_cmp++;
        if (bus.bus_err !== 1'b0 || bus.if_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_pulse: bus_err=%b if_ready=%b, required 0 0", bus.bus_err, bus.if_ready);
        end
        ack_wait = 0;
        bus.if_addr = 32'h0000_0044;
        bus.if_req = 1'b1;
        sb.push_back(mk(1'b0, mem_model(32'h44), 1'b0));
        wait_ready(1'b0, 20, cyc, ce_cyc, ok);
        e = sb.pop_front();
        $display("txn IF addr=00000044 rdata=%h err=%b", bus.if_rdata, bus.bus_err);
        n_cmp++;
        if (!ok || bus.if_rdata !== e.rdata || bus.bus_err !== e.err) begin
            n_bad++;
            $display("FAIL timeout_recover: ready=%b rdata=%h err=%b, required 1 %h %b", ok, bus.if_rdata, bus.bus_err, e.rdata, e.err);
        end
        bus.if_req = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_ack_at_timeout();
        exp_t e;
        int cyc, ce_cyc;
        bit ok;
        ack_wait = 14;
        bus.dm_addr = 32'h0000_0600; bus.dm_we = 1'b0; bus.dm_sel = 4'hF;
        bus.dm_req = 1'b1;
        sb.push_back(mk(1'b1, mem_model(32'h600), 1'b0));
        wait_ready(1'b1, 40, cyc, ce_cyc, ok);
        e = sb.pop_front();
        $display("txn DM addr=00000600 late ack rdata=%h err=%b", bus.dm_rdata, bus.bus_err);
        n_cmp++;
        if (!ok || ce_cyc != 15 || bus.bus_err !== e.err || bus.dm_rdata !== e.rdata) begin
            n_bad++;
            $display("FAIL ack_at_timeout: ready=%b ce=%0d err=%b rdata=%h, required 1 15 %b %h",
                     ok, ce_cyc, bus.bus_err, bus.dm_rdata, e.err, e.rdata);
        end
        bus.dm_req = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_idle_ack();
        bit seen;
        idle_ack = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            tick();
            if (bus.mem_ce === 1'b1 || bus.if_ready === 1'b1 || bus.dm_ready === 1'b1 || bus.bus_err === 1'b1) seen = 1'b1;
        end
        idle_ack = 1'b0;
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL idle_ack: activity=%b, required 0", seen);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int cyc, ce_cyc;
        bit ok, seen;
        ack_wait = -1;
        bus.dm_addr = 32'h0000_0500; bus.dm_we = 1'b0; bus.dm_sel = 4'hF;
        bus.dm_req = 1'b1;
        repeat (3) tick();
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.mem_ce !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_async: mem_ce=%b, required 0", bus.mem_ce);
        end
        ack_wait = 0;
        seen = 1'b0;
        repeat (2) begin
            tick();
            if (bus.dm_ready === 1'b1) seen = 1'b1;
        end
        rst = 1'b1;
        sb.push_back(mk(1'b1, mem_model(32'h500), 1'b0));
        tick();
        if (bus.dm_ready === 1'b1) seen = 1'b1;
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL rst_no_ready: dm_ready seen=%b, required 0", seen);
        end
        n_cmp++;
        if (bus.mem_ce !== 1'b1 || bus.mem_addr !== 32'h500) begin
            n_bad++;
            $display("FAIL rst_regrant: ce=%b addr=%h, required 1 00000500", bus.mem_ce, bus.mem_addr);
        end
        wait_ready(1'b1, 20, cyc, ce_cyc, ok);
        e = sb.pop_front();
        $display("txn DM addr=00000500 after reset rdata=%h", bus.dm_rdata);
        n_cmp++;
        if (!ok || bus.dm_rdata !== e.rdata) begin
            n_bad++;
            $display("FAIL rst_complete: ready=%b rdata=%h, required 1 %h", ok, bus.dm_rdata, e.rdata);
        end
        bus.dm_req = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_simultaneous();
        test_store();
        test_starve();
        test_timeout();
        test_ack_at_timeout();
        test_idle_ack();
        test_reset_mid();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_left: entries=%0d, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: max cycles waited for mem_ack before an access is aborted (range 1..255).
REQ-002 Parameter STARVE_MAX, default 4: consecutive data grants allowed while a fetch is pending.
REQ-003 Port clk  in  1  sole clock, rising edge.
REQ-004 Port rst  in  1  asynchronous, active-low reset.
REQ-005 Ports if_req in 1, if_addr in 32: instruction-fetch request and word address.
REQ-006 Ports if_rdata out 32, if_ready out 1: fetched word and one-cycle completion pulse.
REQ-007 Ports dm_req in 1, dm_we in 1, dm_sel in 4, dm_addr in 32, dm_wdata in 32: data-memory request, write enable, byte lanes, address, write data.
REQ-008 Ports dm_rdata out 32, dm_ready out 1: load data and one-cycle completion pulse.
REQ-009 Ports mem_ce out 1, mem_we out 1, mem_sel out 4, mem_addr out 32, mem_wdata out 32: shared single-port memory command.
REQ-010 Ports mem_rdata in 32, mem_ack in 1: memory read data and completion, any latency >= 0 wait cycles.
REQ-011 Port stall_req out 1: pipeline stall request to the control unit.
REQ-012 Port bus_err out 1: one-cycle pulse on access timeout.

Function
REQ-013 FSM states IDLE, SERVE_IF, SERVE_DM; exactly one access in flight at a time.
REQ-014 IDLE grant: dm_req wins over if_req, except when starve_cnt == STARVE_MAX and if_req is pending, in which case if_req wins.
REQ-015 starve_cnt increments on each DM grant made while if_req is high, clears on every IF grant, and saturates at STARVE_MAX.
REQ-016 On grant, the arbiter latches the address, we, sel and wdata into registers; the mem_* outputs are driven only from these registers.
REQ-017 In SERVE_IF: mem_ce=1, mem_we=0, mem_sel=4'b1111, mem_addr=latched if_addr.
REQ-018 In SERVE_DM: mem_ce=1, mem_we=latched dm_we, mem_sel=latched dm_sel, mem_addr/mem_wdata latched.
REQ-019 In IDLE: mem_ce=0, mem_we=0, mem_sel=0; mem_addr/mem_wdata hold their last values.
REQ-020 On mem_ack in SERVE_x: capture mem_rdata into x_rdata, pulse x_ready for exactly one cycle on the next cycle, and return to IDLE.
REQ-021 Latency: req seen in IDLE at edge N, zero-wait ack -> ready high in the cycle following edge N+2.
REQ-022 A dm write completion still pulses dm_ready; dm_rdata is left unchanged on writes.
REQ-023 In IDLE, a requester whose ready is high in the current cycle is not eligible for grant; a req held high in the following cycle is a new access (back-to-back allowed).
REQ-024 The wait counter clears on grant and increments each SERVE cycle without ack; reaching TIMEOUT -> bus_err pulse, x_ready pulse, x_rdata=0, return to IDLE.
REQ-025 mem_ack in IDLE is ignored.
REQ-026 mem_ack arriving in the same cycle the timeout is reached: ack wins and bus_err stays 0.
REQ-027 Definition: stall_req = (if_req & ~if_ready) | (dm_req & ~dm_ready), combinational.
REQ-028 A request dropped before ready is undefined use; an in-flight access still completes normally.

Reset
REQ-029 While rst=0, asynchronously: state IDLE; starve_cnt and wait counter 0; all outputs 0, including if_rdata, dm_rdata, mem_addr and mem_wdata.
REQ-030 Reset asserted mid-access aborts the access with no ready pulse; the first grant is possible on the first edge after release.

Verification
REQ-031 Zero-wait fetch: if_req=1, if_addr=0x0000_0010, mem_ack every SERVE cycle, mem_rdata=0x3C01_1234 -> mem_ce high 1 cycle, if_ready pulse with if_rdata=0x3C01_1234, stall_req=0 after ready.
REQ-032 Simultaneous if_req and dm_req (load 0x0000_0100), ack after 2 waits -> DM served first, then IF; dm_ready precedes if_ready; stall_req is high until each respective ready.
REQ-033 Store with dm_sel=4'b0011, dm_wdata=0xAABB_CCDD -> mem_we=1, mem_sel=0011, mem_wdata=0xAABB_CCDD; dm_ready pulses; dm_rdata unchanged.
REQ-034 dm_req and if_req held high continuously -> grant order DM x4, IF, DM x4, IF...
REQ-035 mem_ack never asserted -> after 15 SERVE cycles bus_err=1 and if_ready=1 with if_rdata=0 for one cycle; the next request is served normally.
REQ-036 rst driven low during a SERVE_DM wait -> mem_ce=0 immediately and no dm_ready; after release, pending dm_req is granted on the first edge.
